// File: rtl/cc_packer_if.sv
// Handshake bundle for cc_packer: symbol input with flush request, and
// packed word output with length tag and running word count.
interface cc_packer_if #(
  parameter int SYM_W = 2,
  parameter int SYMS  = 8
);
  localparam int OUT_W = SYM_W * SYMS;
  localparam int LEN_W = $clog2(SYMS) + 1;

  logic [SYM_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush_req;
  logic [OUT_W-1:0] out_data;
  logic [LEN_W-1:0] out_len;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      word_cnt;

  // Producer/consumer side that drives symbols and accepts words.
  modport master (
    output in_data, in_valid, flush_req, out_ready,
    input  in_ready, out_data, out_len, out_valid, word_cnt
  );

  // The packer itself.
  modport slave (
    input  in_data, in_valid, flush_req, out_ready,
    output in_ready, out_data, out_len, out_valid, word_cnt
  );
endinterface

// File: rtl/cc_packer.sv
// Packs SYMS cc symbols LSB-first into OUT_W-bit words, buffers completed
// words in a first-word-fall-through FIFO, and emits zero-padded partial
// words on flush_req tagged with their symbol count.
module cc_packer #(
  parameter int SYM_W = 2,
  parameter int SYMS  = 8,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  cc_packer_if.slave bus
);
  localparam int OUT_W = SYM_W * SYMS;
  localparam int LEN_W = $clog2(SYMS) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [LEN_W-1:0] LAST_SLOT = LEN_W'(SYMS - 1);
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(SYMS);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  typedef enum logic {FILL, FLUSH_PEND} state_t;

  state_t           state, state_d;
  logic [OUT_W-1:0] acc, acc_d, acc_with;
  logic [LEN_W-1:0] slot, slot_d, slot_after;
  logic             in_ready, accept;
  logic             push, pop, room, out_valid;
  logic [OUT_W-1:0] push_data;
  logic [LEN_W-1:0] push_len;

  logic [OUT_W-1:0] mem_data [DEPTH];
  logic [LEN_W-1:0] mem_len  [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [15:0]      word_cnt;

  assign out_valid     = (fifo_cnt != '0);
  assign pop           = out_valid & bus.out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign room          = (fifo_cnt < FULL_CNT) | pop;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_len   = out_valid ? mem_len[rd_ptr]  : '0;
  assign bus.word_cnt  = word_cnt;

  // Next-state, accumulator update and push decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d    = state;
    acc_d      = acc;
    slot_d     = slot;
    acc_with   = acc;
    slot_after = slot;
    in_ready   = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    push_data  = acc;
    push_len   = slot;
    case (state)
      FILL: begin
        // The last slot completes a word, so it needs a free FIFO entry.
        in_ready = (slot < LAST_SLOT) | room;
        accept   = bus.in_valid & in_ready;
        if (accept) begin
          for (int k = 0; k < SYMS; k++) begin
            if (slot == LEN_W'(k)) acc_with[k*SYM_W +: SYM_W] = bus.in_data;
          end
          slot_after = slot + LEN_W'(1);
        end
        acc_d  = acc_with;
        slot_d = slot_after;
        if (accept && slot == LAST_SLOT) begin
          push      = 1'b1;
          push_data = acc_with;
          push_len  = FULL_LEN;
          acc_d     = '0;
          slot_d    = '0;
        end else if (bus.flush_req && slot_after != '0) begin
          if (room) begin
            push      = 1'b1;
            push_data = acc_with;
            push_len  = slot_after;
            acc_d     = '0;
            slot_d    = '0;
          end else begin
            state_d = FLUSH_PEND;
          end
        end
      end
      FLUSH_PEND: begin
        if (room) begin
          push    = 1'b1;
          acc_d   = '0;
          slot_d  = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, accumulator and word counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
    if (rst) begin
      state    <= FILL;
      acc      <= '0;
      slot     <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      slot  <= slot_d;
      if (push) word_cnt <= word_cnt + 16'd1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; fifo_cnt gates it and the outputs are forced to 0 when empty.
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_len[wr_ptr]  <= push_len;
    end
  end
endmodule

// File: tb/tb_cc_packer.sv
// Self-checking bench for cc_packer: a reference packer model queues the
// expected words as symbols are driven; a monitor pops and compares each
// word as the DUT hands it out.
module tb_cc_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cc_packer_if #(.SYM_W(2), .SYMS(8)) bus ();

  cc_packer #(.SYM_W(2), .SYMS(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  len;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] m_acc  = '0;
  int          m_slot = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_push();
    word_t w;
    w.data = m_acc;
    w.len  = 4'(m_slot);
    exp_q.push_back(w);
    m_acc  = '0;
    m_slot = 0;
  endtask

  // Drive one symbol (optionally with flush_req) and hold it until accepted.
  task automatic send(input logic [1:0] d, input bit fl);
    int n = 0;
    @(negedge clk);
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.flush_req = fl;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
    m_acc[m_slot*2 +: 2] = d;
    m_slot++;
    if (m_slot == 8) model_push();
    else if (fl) model_push();
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    if (m_slot > 0) model_push();
  endtask

  task automatic set_out_ready(input logic v);
    @(posedge clk);
    #1;
    bus.out_ready = v;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_acc  = '0;
    m_slot = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every popped word must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(w.data));
        check("out_len", 32'(bus.out_len), 32'(w.len));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_len", 32'(bus.out_len), 32'd0);
    check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: single full word 0xE4E4
    set_out_ready(1'b1);
    for (int i = 0; i < 8; i++) send(2'(i % 4), 1'b0);
    wait_drain();
    check("t1_word_cnt", 32'(bus.word_cnt), 32'd1);

    // 2: back-pressure, two words stored, in_ready drops at slot 7
    set_out_ready(1'b0);
    for (int i = 0; i < 23; i++) send(2'd3, 1'b0);
    @(negedge clk);
    check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("t2_word_cnt", 32'(bus.word_cnt), 32'd3);
    check("t2_out_valid", 32'(bus.out_valid), 32'd1);
    fork
      send(2'd3, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t2_word_cnt_end", 32'(bus.word_cnt), 32'd4);

    // 3: partial flush 0x0039 len 3, then a no-op flush
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    flush();
    wait_drain();
    check("t3_word_cnt", 32'(bus.word_cnt), 32'd5);
    flush();
    repeat (3) @(negedge clk);
    check("t3_noop_word_cnt", 32'(bus.word_cnt), 32'd5);
    check("t3_noop_out_valid", 32'(bus.out_valid), 32'd0);

    // 4: symbol and flush in the same cycle -> 0x0200 len 5
    for (int i = 0; i < 4; i++) send(2'd0, 1'b0);
    send(2'd2, 1'b1);
    wait_drain();
    check("t4_word_cnt", 32'(bus.word_cnt), 32'd6);

    // 5: flush with a full FIFO waits in FLUSH_PEND
    set_out_ready(1'b0);
    for (int i = 0; i < 16; i++) send(2'(3 - (i % 4)), 1'b0);
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    flush();
    check("t5_pend_in_ready", 32'(bus.in_ready), 32'd0);
    check("t5_pend_word_cnt", 32'(bus.word_cnt), 32'd8);
    set_out_ready(1'b1);
    set_out_ready(1'b0);
    @(negedge clk);
    check("t5_after_pop_word_cnt", 32'(bus.word_cnt), 32'd9);
    check("t5_after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    set_out_ready(1'b1);
    wait_drain();

    // 6: reset mid-operation discards FIFO contents and the partial word
    set_out_ready(1'b0);
    for (int i = 0; i < 13; i++) send(2'd1, 1'b0);
    check("t6_pre_word_cnt", 32'(bus.word_cnt), 32'd10);
    check("t6_pre_out_valid", 32'(bus.out_valid), 32'd1);
    do_reset();
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_word_cnt", 32'(bus.word_cnt), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    set_out_ready(1'b1);
    for (int i = 0; i < 8; i++) send(2'(3 - (i % 4)), 1'b0);
    wait_drain();
    check("t6_word_cnt_end", 32'(bus.word_cnt), 32'd1);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
